// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: shares one core-side req/gnt/rvalid data port between
// N_MASTERS requesters (e.g. instruction fetch and LSU) in front of the
// core-to-AXI bridge.
//  - Round-robin selection. The selection is locked on the chosen master until
//    the slave grants, because the slave may take address and data on
//    different cycles.
//  - An owner FIFO records the master of every granted transaction, so each
//    response is routed back to its issuer, strictly in grant order.
//  - All request/grant/response paths are combinational. Only the
//    arbitration and bookkeeping state is registered.
// Build option: define CORE_ARB_FIXED_PRIO_EN for fixed-priority unlocked
// selection (lowest index wins, no round-robin pointer). Lock, FIFO and error
// behaviour are identical in both builds.
module core_bus_arbiter #(
  parameter int unsigned N_MASTERS          = 2,
  parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
  parameter int unsigned MAX_OUTSTANDING    = 2
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  // master side
  input  logic [N_MASTERS-1:0]                    m_req_i,
  input  logic [N_MASTERS*AXI4_ADDRESS_WIDTH-1:0] m_addr_i,
  input  logic [N_MASTERS-1:0]                    m_we_i,
  input  logic [N_MASTERS*4-1:0]                  m_be_i,
  input  logic [N_MASTERS*32-1:0]                 m_wdata_i,
  output logic [N_MASTERS-1:0]                    m_gnt_o,
  output logic [N_MASTERS-1:0]                    m_rvalid_o,
  output logic [31:0]                             m_rdata_o,
  // slave side
  output logic                                    s_req_o,
  output logic [AXI4_ADDRESS_WIDTH-1:0]           s_addr_o,
  output logic                                    s_we_o,
  output logic [3:0]                              s_be_o,
  output logic [31:0]                             s_wdata_o,
  input  logic                                    s_gnt_i,
  input  logic                                    s_rvalid_i,
  input  logic [31:0]                             s_rdata_i,
  // sticky protocol error
  output logic                                    err_o
);

  localparam int unsigned AW   = AXI4_ADDRESS_WIDTH;
  localparam int unsigned DW   = 32;
  localparam int unsigned BW   = 4;
  localparam int unsigned IDXW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned PTRW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNTW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_MASTERS - 1);
  localparam logic [PTRW-1:0] LAST_PTR = PTRW'(MAX_OUTSTANDING - 1);
  localparam logic [CNTW-1:0] DEPTH    = CNTW'(MAX_OUTSTANDING);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

  // lock FSM
  lock_state_t     r_state;
  lock_state_t     w_state_nxt;
  logic [IDXW-1:0] r_owner;
  logic [IDXW-1:0] w_owner_nxt;

  // owner FIFO
  logic [IDXW-1:0] r_fifo [MAX_OUTSTANDING];
  logic [PTRW-1:0] r_wr_ptr;
  logic [PTRW-1:0] r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic            r_err;

  // datapath
  logic            w_lock;
  logic            w_any_req;
  logic            w_can_issue;
  logic            w_grant;
  logic            w_fifo_nempty;
  logic            w_push;
  logic            w_pop;
  logic            w_spurious;
  logic [IDXW-1:0] w_arb_sel;
  logic [IDXW-1:0] w_sel;
  logic [IDXW-1:0] w_head;

  // Advance a FIFO pointer, wrapping at the FIFO depth (depth need not be a power of 2).
  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTRW'(1);
  endfunction

  assign w_lock        = (r_state == ST_LOCKED);
  assign w_any_req     = |m_req_i;
  assign w_fifo_nempty = (r_count != '0);
  // A response popping in this cycle frees the slot a new grant would use.
  assign w_can_issue   = (r_count < DEPTH) | s_rvalid_i;
  assign w_sel         = w_lock ? r_owner : w_arb_sel;
  assign w_grant       = s_req_o & s_gnt_i;
  assign w_push        = w_grant;
  assign w_pop         = s_rvalid_i & w_fifo_nempty;
  // A push in the same cycle cannot satisfy a response: it is still spurious.
  assign w_spurious    = s_rvalid_i & ~w_fifo_nempty;
  assign w_head        = r_fifo[r_rd_ptr];

  assign s_req_o   = w_can_issue & (w_lock | w_any_req);
  assign m_rdata_o = s_rdata_i;
  assign err_o     = r_err;

`ifdef CORE_ARB_FIXED_PRIO_EN
  // Unlocked selection: lowest-index requesting master wins.
  always_comb begin
    w_arb_sel = '0;
    for (int i = int'(N_MASTERS) - 1; i >= 0; i--) begin
      if (m_req_i[IDXW'(i)]) begin
        w_arb_sel = IDXW'(i);
      end
    end
  end
`else
  logic [IDXW-1:0] r_rr_ptr;

  // Unlocked selection: first requester at or above r_rr_ptr, wrapping around.
  always_comb begin
    logic            found;
    logic [IDXW-1:0] cand;
    int              cand_i;
    w_arb_sel = '0;
    found     = 1'b0;
    cand      = '0;
    cand_i    = 0;
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      cand_i = int'(r_rr_ptr) + i;
      if (cand_i >= int'(N_MASTERS)) begin
        cand_i = cand_i - int'(N_MASTERS);
      end
      cand = IDXW'(cand_i);
      if (!found && m_req_i[cand]) begin
        found     = 1'b1;
        w_arb_sel = cand;
      end
    end
  end

  // Round-robin pointer: move just past the master that was granted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= (w_sel == LAST_IDX) ? '0 : w_sel + IDXW'(1);
    end
  end
`endif

  // Route the selected master's request fields to the slave.
  always_comb begin
    s_addr_o  = '0;
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_wdata_o = '0;
    for (int k = 0; k < int'(N_MASTERS); k++) begin
      if (w_sel == IDXW'(k)) begin
        s_addr_o  = m_addr_i[k*int'(AW) +: AW];
        s_we_o    = m_we_i[k];
        s_be_o    = m_be_i[k*int'(BW) +: BW];
        s_wdata_o = m_wdata_i[k*int'(DW) +: DW];
      end
    end
  end

  // Per-master grant (to the selected master) and response (to the FIFO head).
  for (genvar g = 0; g < int'(N_MASTERS); g++) begin : g_master
    assign m_gnt_o[g]    = w_grant & (w_sel == IDXW'(g));
    assign m_rvalid_o[g] = w_pop & (w_head == IDXW'(g));
  end

  // Lock FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_UNLOCKED;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // Lock FSM next state: hold an issued-but-ungranted selection until the slave grants.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    case (r_state)
      ST_UNLOCKED: begin
        if (s_req_o && !s_gnt_i) begin
          w_state_nxt = ST_LOCKED;
          w_owner_nxt = w_sel;
        end
      end
      ST_LOCKED: begin
        if (s_gnt_i) begin
          w_state_nxt = ST_UNLOCKED;
        end
      end
      default: begin
        w_state_nxt = ST_UNLOCKED;
      end
    endcase
  end

  // Owner FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Owner FIFO storage: entries are only read once written, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_sel;
    end
  end

  // Sticky error on any response with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_spurious) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter (N_MASTERS=2, 32-bit address, depth 2).
// Expected grants and responses are queued as stimulus is issued; a monitor
// pops and compares whenever the DUT presents a grant or a response.
module tb_core_bus_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 32;

  typedef struct packed {
    logic [1:0]  who;
    logic [31:0] data;
  } rsp_t;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    m_req_i;
  logic [N*AW-1:0] m_addr_i;
  logic [N-1:0]    m_we_i;
  logic [N*4-1:0]  m_be_i;
  logic [N*32-1:0] m_wdata_i;
  logic [N-1:0]    m_gnt_o;
  logic [N-1:0]    m_rvalid_o;
  logic [31:0]     m_rdata_o;
  logic            s_req_o;
  logic [AW-1:0]   s_addr_o;
  logic            s_we_o;
  logic [3:0]      s_be_o;
  logic [31:0]     s_wdata_o;
  logic            s_gnt_i;
  logic            s_rvalid_i;
  logic [31:0]     s_rdata_i;
  logic            err_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic [1:0] q_gnt[$];
  rsp_t       q_rsp[$];
  logic [1:0] exp_t1 [5];

  core_bus_arbiter #(
    .N_MASTERS(N), .AXI4_ADDRESS_WIDTH(AW), .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_req_i(m_req_i), .m_addr_i(m_addr_i), .m_we_i(m_we_i), .m_be_i(m_be_i),
    .m_wdata_i(m_wdata_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
    .m_rdata_o(m_rdata_o), .s_req_o(s_req_o), .s_addr_o(s_addr_o),
    .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i),
    .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_rsp(input logic [1:0] who, input logic [31:0] data);
    rsp_t r;
    r.who  = who;
    r.data = data;
    q_rsp.push_back(r);
  endtask

  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                       input logic [31:0] rdata);
    m_req_i    = req;
    s_gnt_i    = gnt;
    s_rvalid_i = rv;
    s_rdata_i  = rdata;
  endtask

  // Outputs settle between the drive point (posedge+1) and the next negedge.
  task automatic to_mid();
    @(negedge clk_i);
  endtask

  task automatic to_next();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: every grant and every response must match the head of its queue.
  always @(negedge clk_i) begin
    if ((|m_gnt_o) === 1'b1) begin
      n_tests++;
      if (q_gnt.size() == 0) begin
        n_fail++;
        $display("FAIL mon_gnt: unexpected grant %b (t=%0t)", m_gnt_o, $time);
      end else begin
        logic [1:0] e;
        e = q_gnt.pop_front();
        if (m_gnt_o !== e) begin
          n_fail++;
          $display("FAIL mon_gnt: got %b, expected %b (t=%0t)", m_gnt_o, e, $time);
        end
      end
    end
    if ((|m_rvalid_o) === 1'b1) begin
      n_tests++;
      if (q_rsp.size() == 0) begin
        n_fail++;
        $display("FAIL mon_rsp: unexpected rvalid %b (t=%0t)", m_rvalid_o, $time);
      end else begin
        rsp_t e;
        e = q_rsp.pop_front();
        if (m_rvalid_o !== e.who || m_rdata_o !== e.data) begin
          n_fail++;
          $display("FAIL mon_rsp: got %b/0x%0h, expected %b/0x%0h (t=%0t)",
                   m_rvalid_o, m_rdata_o, e.who, e.data, $time);
        end
      end
    end
  end

  initial begin
`ifdef CORE_ARB_FIXED_PRIO_EN
    exp_t1 = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_t1 = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`endif
    rst_i     = 1'b1;
    m_addr_i  = '0;
    m_we_i    = '0;
    m_be_i    = '0;
    m_wdata_i = '0;
    drive(2'b00, 1'b0, 1'b0, 32'h0);

    // Reset state
    @(posedge clk_i);
    to_next();
    to_mid();
    chk("rst_s_req", 64'(s_req_o), 64'd0);
    chk("rst_gnt", 64'(m_gnt_o), 64'd0);
    chk("rst_rvalid", 64'(m_rvalid_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    to_next();
    rst_i = 1'b0;

    // Both masters streaming, slave grants every cycle, response one cycle later
    m_addr_i  = {32'h0000_2000, 32'h0000_1000};
    m_we_i    = 2'b10;
    m_be_i    = {4'hF, 4'h3};
    m_wdata_i = {32'hDEAD_BEEF, 32'h1111_1111};
    for (int c = 0; c < 6; c++) begin
      drive((c < 5) ? 2'b11 : 2'b00, c < 5, c > 0, 32'hA000_0000 + 32'(c));
      if (c < 5) q_gnt.push_back(exp_t1[c]);
      if (c > 0) push_rsp(exp_t1[c-1], 32'hA000_0000 + 32'(c));
      to_mid();
      if (c < 5) begin
        chk("t1_s_req", 64'(s_req_o), 64'd1);
        chk("t1_addr", 64'(s_addr_o), exp_t1[c][1] ? 64'h2000 : 64'h1000);
        chk("t1_we", 64'(s_we_o), exp_t1[c][1] ? 64'd1 : 64'd0);
        chk("t1_be", 64'(s_be_o), exp_t1[c][1] ? 64'hF : 64'h3);
        chk("t1_wdata", 64'(s_wdata_o), exp_t1[c][1] ? 64'hDEAD_BEEF : 64'h1111_1111);
      end else begin
        chk("t1_idle_s_req", 64'(s_req_o), 64'd0);
      end
      to_next();
    end

    // Selection locked on m0 while the slave stalls, m1 requesting meanwhile
    m_addr_i = {32'h0000_0200, 32'h0000_0100};
    m_we_i   = 2'b00;
    begin
      logic [1:0]  req2 [5];
      logic [1:0]  gnt2 [5];
      logic [31:0] adr2 [5];
      req2 = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b10};
      gnt2 = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
      adr2 = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h200};
      for (int c = 0; c < 5; c++) begin
        drive(req2[c], c >= 3, 1'b0, 32'h0);
        if (c >= 3) q_gnt.push_back(gnt2[c]);
        to_mid();
        chk("t2_s_req", 64'(s_req_o), 64'd1);
        chk("t2_addr", 64'(s_addr_o), 64'(adr2[c]));
        chk("t2_gnt", 64'(m_gnt_o), 64'(gnt2[c]));
        to_next();
      end
    end

    // FIFO full (m0 then m1 outstanding): request stalls until a response frees a slot
    m_addr_i = {32'h0000_0400, 32'h0000_0300};
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    to_mid();
    chk("t3_full_s_req", 64'(s_req_o), 64'd0);
    chk("t3_full_gnt", 64'(m_gnt_o), 64'd0);
    to_next();
    drive(2'b01, 1'b1, 1'b1, 32'hB000_0000);
    q_gnt.push_back(2'b01);
    push_rsp(2'b01, 32'hB000_0000);
    to_mid();
    chk("t3_pop_s_req", 64'(s_req_o), 64'd1);
    chk("t3_pop_addr", 64'(s_addr_o), 64'h300);
    to_next();
    drive(2'b00, 1'b0, 1'b1, 32'hB000_0001);
    push_rsp(2'b10, 32'hB000_0001);
    to_next();
    drive(2'b00, 1'b0, 1'b1, 32'hB000_0002);
    push_rsp(2'b01, 32'hB000_0002);
    to_next();

    // Spurious responses: FIFO empty, then empty with a push in the same cycle
    drive(2'b00, 1'b0, 1'b1, 32'hC000_0000);
    to_mid();
    chk("t4_spur_rvalid", 64'(m_rvalid_o), 64'd0);
    chk("t4_err_before", 64'(err_o), 64'd0);
    to_next();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    to_mid();
    chk("t4_err_set", 64'(err_o), 64'd1);
    to_next();
    drive(2'b01, 1'b1, 1'b1, 32'hC000_0002);
    q_gnt.push_back(2'b01);
    to_mid();
    chk("t4_push_spur_rvalid", 64'(m_rvalid_o), 64'd0);
    to_next();
    drive(2'b00, 1'b0, 1'b1, 32'hC000_0003);
    push_rsp(2'b01, 32'hC000_0003);
    to_mid();
    chk("t4_err_sticky", 64'(err_o), 64'd1);
    to_next();

    // Reset while locked with a transaction outstanding discards everything
    m_addr_i = {32'h0000_5200, 32'h0000_5100};
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    q_gnt.push_back(2'b01);
    to_next();
    drive(2'b10, 1'b0, 1'b0, 32'h0);
    to_mid();
    chk("t5_lock_addr", 64'(s_addr_o), 64'h5200);
    to_next();
    rst_i = 1'b1;
    to_next();
    rst_i = 1'b0;
    drive(2'b11, 1'b0, 1'b0, 32'h0);
    to_mid();
    chk("t5_post_rst_s_req", 64'(s_req_o), 64'd1);
    chk("t5_post_rst_addr", 64'(s_addr_o), 64'h5100);
    chk("t5_post_rst_err", 64'(err_o), 64'd0);
    to_next();
    rst_i = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    to_next();
    rst_i = 1'b0;
    drive(2'b00, 1'b0, 1'b1, 32'hD000_0000);
    to_mid();
    chk("t5_late_rvalid", 64'(m_rvalid_o), 64'd0);
    to_next();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    to_mid();
    chk("t5_late_err", 64'(err_o), 64'd1);
    to_next();

    // Every queued expectation must have been consumed
    to_next();
    chk("end_gnt_queue", 64'(q_gnt.size()), 64'd0);
    chk("end_rsp_queue", 64'(q_rsp.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
